// File: rtl/ram_dumper_if.sv
// ram_dumper_if: bundles the dump request, RAM read port and dump output
// stream of ram_dumper into one interface.
//   master modport : the environment side. It issues start and the range,
//                    returns RAM read data and supplies out_ready.
//   slave modport  : the dumper side. It reads the RAM, presents the words,
//                    and reports busy, cpu_hold and done.
interface ram_dumper_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();
  // Dump request
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  // RAM read port (data returns one cycle after mem_rd)
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  // Dump output stream
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  // Status
  logic              busy;
  logic              cpu_hold;
  logic              done;

  modport master (
    output start, start_addr, end_addr, mem_data, out_ready,
    input  mem_rd, mem_addr, out_valid, out_addr, out_data, busy, cpu_hold, done
  );

  modport slave (
    input  start, start_addr, end_addr, mem_data, out_ready,
    output mem_rd, mem_addr, out_valid, out_addr, out_data, busy, cpu_hold, done
  );
endinterface

// File: rtl/ram_dumper.sv
// ram_dumper: streams out an inclusive RAM address range, one word at a time.
// The range wraps through address 0 when end_addr < start_addr.
// Each word takes three states:
//   READ : strobes the RAM.
//   CAPT : latches the returned data.
//   SEND : presents the word until the consumer accepts it.
// Ports:
//   clk : single clock. All state changes on the rising edge.
//   rst : synchronous, active-high reset.
//   bus : ram_dumper_if.slave. It carries:
//         - the start/start_addr/end_addr request,
//         - the mem_rd/mem_addr/mem_data RAM port,
//         - the out_valid/out_ready/out_addr/out_data stream,
//         - the busy, cpu_hold and done status outputs.
// All outputs are registered.
module ram_dumper #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  ram_dumper_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    CAPT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  // One bit wider than the address so that a full 2^ADDR_W-word dump fits.
  logic [ADDR_W:0]   count_reg;
  logic              mem_rd_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic              out_valid_reg;
  logic [ADDR_W-1:0] out_addr_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              busy_reg;
  logic              done_reg;

  // The next address is computed at address width, so it wraps from the top
  // of the RAM to 0.
  logic [ADDR_W-1:0] addr_inc;
  // Range length minus one, computed at address width, so the range wraps
  // through 0.
  logic [ADDR_W-1:0] span;

  assign addr_inc = addr_reg + 1'b1;
  assign span     = bus.end_addr - bus.start_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      count_reg     <= '0;
      mem_rd_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_addr_reg  <= '0;
      out_data_reg  <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // The range is sampled only here, so later changes on the range
          // inputs cannot disturb a dump in progress.
          if (bus.start) begin
            addr_reg     <= bus.start_addr;
            count_reg    <= {1'b0, span} + (ADDR_W+1)'(1);
            mem_rd_reg   <= 1'b1;
            mem_addr_reg <= bus.start_addr;
            busy_reg     <= 1'b1;
            state_reg    <= READ;
          end
        end

        READ: begin
          // The read strobe lasts exactly one cycle. The data arrives
          // during CAPT.
          mem_rd_reg <= 1'b0;
          state_reg  <= CAPT;
        end

        CAPT: begin
          out_data_reg  <= bus.mem_data;
          out_addr_reg  <= addr_reg;
          out_valid_reg <= 1'b1;
          state_reg     <= SEND;
        end

        SEND: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            if (count_reg > (ADDR_W+1)'(1)) begin
              addr_reg     <= addr_inc;
              count_reg    <= count_reg - (ADDR_W+1)'(1);
              mem_rd_reg   <= 1'b1;
              mem_addr_reg <= addr_inc;
              state_reg    <= READ;
            end else begin
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end
          end
        end

        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_rd    = mem_rd_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_addr  = out_addr_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.busy      = busy_reg;
  // The CPU is held off the RAM for exactly as long as the dumper is busy.
  assign bus.cpu_hold  = busy_reg;
  assign bus.done      = done_reg;

endmodule

// File: tb/tb_ram_dumper.sv
// tb_ram_dumper: directed bench for ram_dumper with a scoreboard of
// expected (addr, data) words. The bench pushes the expected words when it
// issues a start, and pops them as the DUT presents each word.
// A registered RAM model returns data one cycle after mem_rd.
// The bench drives inputs and samples outputs on the falling clock edge.
module tb_ram_dumper;

  localparam int AW = 8;
  localparam int DW = 8;

  logic clk;
  logic rst;

  ram_dumper_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_dumper #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model with a one-cycle registered read
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_data <= ram[bus.mem_addr];
  end

  // Event counters and free-running cycle count
  int rd_cnt;
  int done_cnt;
  int cyc;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bus.mem_rd) rd_cnt = rd_cnt + 1;
    if (bus.done)   done_cnt = done_cnt + 1;
  end

  int checks;
  int errors;
  logic [15:0] sb[$];   // {addr, data}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_rd"},    bus.mem_rd,    0);
    check({tag, "_mem_addr"},  bus.mem_addr,  0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_addr"},  bus.out_addr,  0);
    check({tag, "_out_data"},  bus.out_data,  0);
    check({tag, "_busy"},      bus.busy,      0);
    check({tag, "_cpu_hold"},  bus.cpu_hold,  0);
    check({tag, "_done"},      bus.done,      0);
  endtask

  // Issues a start and pushes the expected words to the scoreboard.
  // Returns at the falling edge in the first READ cycle.
  task automatic do_start(input logic [AW-1:0] s, input logic [AW-1:0] e);
    logic [AW-1:0] a;
    int n;
    a = s;
    n = int'(logic'(1'b0)) + int'(AW'(e - s)) + 1;
    for (int i = 0; i < n; i++) begin
      sb.push_back({a, ram[a]});
      a = a + 1'b1;
    end
    bus.start = 1'b1;
    bus.start_addr = s;
    bus.end_addr = e;
    @(negedge clk);
    bus.start = 1'b0;
    $display("start %0d..%0d (%0d words)", s, e, n);
  endtask

  // Waits (bounded) for a word and compares it with the scoreboard.
  // It holds out_ready low for 'stall' cycles, then accepts the word.
  // Returns at the falling edge after the handshake.
  task automatic recv(input int stall);
    int t;
    logic [15:0] e;
    t = 0;
    while (!bus.out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!bus.out_valid) begin
      check("out_valid_timeout", bus.out_valid, 1);
      return;
    end
    if (sb.size() == 0) begin
      check("scoreboard_empty", sb.size(), 1);
      return;
    end
    e = sb.pop_front();
    check("out_addr", bus.out_addr, e[15:8]);
    check("out_data", bus.out_data, e[7:0]);
    $display("word addr=%0d data=0x%02h", bus.out_addr, bus.out_data);
    if (stall > 0) begin
      bus.out_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check("stall_valid", bus.out_valid, 1);
        check("stall_data",  bus.out_data,  e[7:0]);
        check("stall_addr",  bus.out_addr,  e[15:8]);
      end
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
  endtask

  // Checks the DONE pulse and the return to idle.
  // Call at the falling edge in the DONE cycle.
  task automatic finish_dump(input string tag);
    check({tag, "_done_hi"}, bus.done, 1);
    check({tag, "_busy_in_done"}, bus.busy, 1);
    @(negedge clk);
    check({tag, "_done_lo"}, bus.done, 0);
    check({tag, "_busy_lo"}, bus.busy, 0);
    check({tag, "_cpu_hold_lo"}, bus.cpu_hold, 0);
  endtask

  int c0;

  initial begin
    checks = 0;
    errors = 0;
    rd_cnt = 0;
    done_cnt = 0;
    cyc = 0;
    for (int i = 0; i < 256; i++) ram[i] = '0;
    bus.mem_data   = '0;
    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.end_addr   = '0;
    bus.out_ready  = 1'b1;
    rst = 1'b1;

    // Reset state. A start raised while rst is high must be ignored.
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    bus.start = 1'b1;
    bus.start_addr = 8'd5;
    bus.end_addr = 8'd6;
    @(negedge clk);
    check("start_in_reset_busy", bus.busy, 0);
    check("start_in_reset_rd", bus.mem_rd, 0);
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset_busy", bus.busy, 0);

    // Two-word dump of addresses 1..2, including first-word latency
    ram[1] = 8'h52;
    ram[2] = 8'd130;
    do_start(8'd1, 8'd2);
    check("read_mem_rd", bus.mem_rd, 1);
    check("read_mem_addr", bus.mem_addr, 1);
    check("read_busy", bus.busy, 1);
    check("read_cpu_hold", bus.cpu_hold, 1);
    check("read_no_valid", bus.out_valid, 0);
    @(negedge clk);
    check("capt_mem_rd", bus.mem_rd, 0);
    check("capt_no_valid", bus.out_valid, 0);
    @(negedge clk);
    check("third_cycle_valid", bus.out_valid, 1);
    recv(0);
    recv(0);
    finish_dump("t1");

    // Range 128..131 with a 5-cycle stall on the first word
    ram[128] = 8'd6;
    ram[129] = 8'd1;
    ram[130] = 8'd2;
    ram[131] = 8'd0;
    rd_cnt = 0;
    done_cnt = 0;
    do_start(8'd128, 8'd131);
    recv(5);
    for (int i = 0; i < 3; i++) recv(0);
    finish_dump("t2");
    check("t2_rd_pulses", rd_cnt, 4);
    check("t2_done_count", done_cnt, 1);

    // Range that wraps through address 0: 255..1
    ram[255] = 8'hAA;
    ram[0] = 8'h00;
    ram[1] = 8'h52;
    done_cnt = 0;
    do_start(8'd255, 8'd1);
    for (int i = 0; i < 3; i++) recv(0);
    finish_dump("t3");
    check("t3_done_count", done_cnt, 1);

    // Full 256-word dump 0..255, three cycles per word
    for (int i = 0; i < 256; i++) ram[i] = 8'(i * 7 + 3);
    do_start(8'd0, 8'd255);
    c0 = cyc;
    for (int i = 0; i < 256; i++) recv(0);
    check("t4_cycles", cyc - c0, 768);
    check("t4_sb_drained", sb.size(), 0);
    finish_dump("t4");

    // Start ignored mid-dump, then a reset abandons the dump
    for (int i = 128; i <= 140; i++) ram[i] = 8'(i + 1);
    ram[139] = 8'hF0;
    do_start(8'd128, 8'd140);
    bus.start = 1'b1;
    bus.start_addr = 8'd0;
    bus.end_addr = 8'd14;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) recv(0);
    check("t5_fourth_read_addr", bus.mem_addr, 131);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("t5_reset");
    sb.delete();
    @(negedge clk);
    check("t5_stays_idle", bus.busy, 0);
    do_start(8'd139, 8'd139);
    recv(0);
    finish_dump("t5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_dumper.md
RAM_DUMPER -- requirements
Module: ram_dumper

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning RAM word width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  one-cycle request to dump a RAM range; sampled only in IDLE.
REQ-006 start_addr  input  ADDR_W  first address of range; sampled with start.
REQ-007 end_addr  input  ADDR_W  last address of range, inclusive; sampled with start.
REQ-008 mem_rd  output  1  RAM read strobe.
REQ-009 mem_addr  output  ADDR_W  RAM read address.
REQ-010 mem_data  input  DATA_W  RAM read data; valid exactly one cycle after mem_rd.
REQ-011 out_valid  output  1  dump word available.
REQ-012 out_ready  input  1  consumer accepts word.
REQ-013 out_addr  output  ADDR_W  address of current dump word.
REQ-014 out_data  output  DATA_W  contents of current dump word.
REQ-015 busy  output  1  high from the cycle after accepted start until DONE exits.
REQ-016 cpu_hold  output  1  equals busy; holds the CPU off the RAM during a dump.
REQ-017 done  output  1  one-cycle pulse when the last word is accepted.

Function
REQ-018 SHALL implement states IDLE, READ, CAPT, SEND, DONE.
REQ-019 IDLE: start=1 latches start_addr into addr, sets count = ((end_addr - start_addr) mod 2^ADDR_W) + 1 in an ADDR_W+1-bit counter, and goes to READ.
REQ-020 READ: mem_rd=1, mem_addr=addr for exactly one cycle, then CAPT.
REQ-021 CAPT: out_data <= mem_data and out_addr <= addr, then SEND.
REQ-022 SEND: out_valid=1; out_data and out_addr held stable until out_valid && out_ready.
REQ-023 Handshake in SEND with count>1: addr <= addr+1 (wraps 2^ADDR_W-1 -> 0), count <= count-1, go to READ.
REQ-024 Handshake in SEND with count==1: go to DONE.
REQ-025 DONE: done=1 for one cycle, then IDLE.
REQ-026 Timing: at least 3 cycles per word (READ, CAPT, SEND); first out_valid in the third cycle after the start edge.
REQ-027 start_addr==end_addr SHALL dump exactly one word.
REQ-028 end_addr < start_addr SHALL wrap through address 0 (e.g. 254..1 = 4 words).
REQ-029 end_addr == start_addr-1 (mod 2^ADDR_W) SHALL dump all 2^ADDR_W words.
REQ-030 start while not IDLE SHALL be ignored; range inputs SHALL NOT affect an active dump.
REQ-031 out_ready high outside SEND SHALL have no effect.
REQ-032 mem_rd SHALL be 0 in every state except READ.

Reset
REQ-033 rst=1 at a rising edge SHALL force IDLE in any state, including mid-dump, and abandon the remaining count.
REQ-034 Reset values: mem_rd=0, mem_addr=0, out_valid=0, out_addr=0, out_data=0, busy=0, cpu_hold=0, done=0, internal addr and count=0.
REQ-035 No start SHALL be accepted in the cycle rst is high.

Verification
REQ-036 Preload RAM[1]=0x52, RAM[2]=130; start 1..2, out_ready=1 -> words (1,0x52), (2,130); done pulse after the second; busy low next cycle.
REQ-037 RAM[128..131]=6,1,2,0, start 128..131, out_ready low for 5 cycles on the first word -> out_data=6 held stable, then 6,1,2,0 in order; exactly 4 mem_rd pulses.
REQ-038 RAM[255]=0xAA, RAM[0]=0x00, RAM[1]=0x52, start 255..1 -> addresses 255,0,1 with data 0xAA,0x00,0x52; done once.
REQ-039 start 0..255 with out_ready=1 -> 256 words, address 0..255 in order; total 3*256 cycles from first READ to DONE.
REQ-040 During a dump of 128..140, pulse start with range 0..14, then assert rst after the 3rd word -> second start ignored; all outputs at reset values next cycle; new start 139..139 returns RAM[139]=0xF0.
